// File: rtl/atom_prefetch_unit_pkg.sv
// Shared definitions for the Atom instruction-fetch front end.
// Holds the default reset PC, the canonical NOP word, the word-align mask
// and the FIFO entry layout used between the top level and the fetch FIFO.
package atom_prefetch_unit_pkg;

  localparam logic [31:0] RESET_PC_ADDRESS = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0013;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  // One buffered fetch: the PC sits in the upper half so the entry reads as {pc, instr}
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetchEntry_t;

  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/atom_prefetch_unit_fifo.sv
// atom_sync_fifo: synchronous FIFO used as the prefetch buffer.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter; clear wins over push and pop.
module atom_sync_fifo
  import atom_prefetch_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wrData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdData_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             doPush;
  logic             doPop;

  assign level_o  = wrPtr_q - rdPtr_q;
  assign full_o   = (level_o == (AW+1)'(DEPTH));
  assign empty_o  = (wrPtr_q == rdPtr_q);
  assign doPush   = push_i & ~full_o;
  assign doPop    = pop_i & ~empty_o;
  assign rdData_o = mem_q[rdPtr_q[AW-1:0]];

  // Pointer update; clear discards everything including a same-cycle push or pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else if (clear_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (doPush && !clear_i) mem_q[wrPtr_q[AW-1:0]] <= wrData_i;
  end

endmodule

// File: rtl/atom_prefetch_unit.sv
// atom_prefetch_unit: sequential instruction fetch over GHPI into a prefetch
// FIFO, presented to decode over valid/ready. Redirect flushes and restarts.
// Optional feature macro: ATOM_PREFETCH_BYPASS_EN (0-cycle latency when the
// FIFO is empty and decode is ready).
module atom_prefetch_unit
  import atom_prefetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_ADDRESS
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  output logic [31:0]              imem_addr_o,
  output logic                     imem_valid_o,
  input  logic                     imem_ack_i,
  input  logic [31:0]              imem_data_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic [31:0]              instr_o,
  output logic [31:0]              pc_o,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [$clog2(DEPTH):0]   fifo_level_o
);

  logic [31:0]           fetchPc_q;
  logic [31:0]           fetchPc_d;
  logic                  xfer;
  logic                  bypassTake;
  logic                  fifoPush;
  logic                  fifoPop;
  logic                  fifoFull;
  logic                  fifoEmpty;
  fetchEntry_t           pushEntry;
  fetchEntry_t           headEntry;

  // Request only while there is room; ready from decode never feeds this
  assign imem_valid_o = rst_ni & ~fifoFull;
  assign imem_addr_o  = fetchPc_q;
  assign xfer         = imem_valid_o & imem_ack_i;

`ifdef ATOM_PREFETCH_BYPASS_EN
  assign bypassTake = fifoEmpty & xfer & ~redirect_i & instr_ready_i;
`else
  assign bypassTake = 1'b0;
`endif

  assign fifoPush        = xfer & ~redirect_i & ~bypassTake;
  assign fifoPop         = ~fifoEmpty & instr_ready_i & ~redirect_i;
  assign pushEntry.pc    = fetchPc_q;
  assign pushEntry.instr = imem_data_i;

  atom_sync_fifo #(
    .WIDTH ($bits(fetchEntry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (redirect_i),
    .push_i   (fifoPush),
    .wrData_i (pushEntry),
    .pop_i    (fifoPop),
    .rdData_o (headEntry),
    .level_o  (fifo_level_o),
    .full_o   (fifoFull),
    .empty_o  (fifoEmpty)
  );

  // Decode-side view: FIFO head, zeros when empty, or the live word when bypassing
  always_comb begin
    instr_valid_o = ~fifoEmpty;
    instr_o       = fifoEmpty ? '0 : headEntry.instr;
    pc_o          = fifoEmpty ? '0 : headEntry.pc;
`ifdef ATOM_PREFETCH_BYPASS_EN
    if (bypassTake) begin
      instr_valid_o = 1'b1;
      instr_o       = imem_data_i;
      pc_o          = fetchPc_q;
    end
`endif
  end

  // Next fetch address: redirect beats a transfer, otherwise hold until acked
  always_comb begin
    fetchPc_d = fetchPc_q;
    if (redirect_i)  fetchPc_d = alignWord(redirect_pc_i);
    else if (xfer)   fetchPc_d = fetchPc_q + 32'd4;
  end

  // Fetch PC register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fetchPc_q <= RESET_PC;
    else         fetchPc_q <= fetchPc_d;
  end

endmodule

// File: tb/tb_atom_prefetch_unit.sv
// Directed self-checking bench for atom_prefetch_unit (DEPTH=4, RESET_PC=0).
// The instruction memory returns addr ^ 32'hC0DE0000 for any fetch.
module tb_atom_prefetch_unit;

  localparam logic [31:0] DATA_KEY = 32'hC0DE_0000;

  logic        clk;
  logic        rstN;
  logic [31:0] imemAddr;
  logic        imemValid;
  logic        imemAck;
  logic [31:0] imemData;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instrValid;
  logic        instrReady;
  logic [2:0]  fifoLevel;

  int compared   = 0;
  int mismatched = 0;

  atom_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .imem_addr_o   (imemAddr),
    .imem_valid_o  (imemValid),
    .imem_ack_i    (imemAck),
    .imem_data_i   (imemData),
    .redirect_i    (redirect),
    .redirect_pc_i (redirectPc),
    .instr_o       (instr),
    .pc_o          (pc),
    .instr_valid_o (instrValid),
    .instr_ready_i (instrReady),
    .fifo_level_o  (fifoLevel)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data is a fixed function of the requested address
  assign imemData = imemAddr ^ DATA_KEY;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    rstN = 1'b0; redirect = 1'b0; redirectPc = '0; imemAck = 1'b0; instrReady = 1'b0;
    step();
  endtask

  task automatic releaseReset();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    applyReset();
    imemAck = 1'b1; instrReady = 1'b1;
    #1;
    check32("rst_imem_valid", 32'(imemValid), 32'd0);
    check32("rst_instr_valid", 32'(instrValid), 32'd0);
    check32("rst_level", 32'(fifoLevel), 32'd0);
    check32("rst_instr", instr, 32'd0);
    check32("rst_pc", pc, 32'd0);
    check32("rst_addr", imemAddr, 32'd0);
  endtask

  task automatic test_stream();
    // inputs already ack=1 ready=1 from test_reset
    releaseReset();
    #1;
    check32("s_first_valid", 32'(imemValid), 32'd1);
    check32("s_first_addr", imemAddr, 32'd0);
`ifdef ATOM_PREFETCH_BYPASS_EN
    check32("s_bypass_valid", 32'(instrValid), 32'd1);
    check32("s_bypass_pc", pc, 32'd0);
`else
    check32("s_no_early_valid", 32'(instrValid), 32'd0);
`endif
    for (int k = 1; k <= 4; k++) begin
      step();
      check32("s_addr", imemAddr, 32'(4*k));
      check32("s_valid", 32'(instrValid), 32'd1);
`ifdef ATOM_PREFETCH_BYPASS_EN
      check32("s_pc", pc, 32'(4*k));
      check32("s_instr", instr, 32'(4*k) ^ DATA_KEY);
`else
      check32("s_pc", pc, 32'(4*(k-1)));
      check32("s_instr", instr, 32'(4*(k-1)) ^ DATA_KEY);
`endif
    end
  endtask

  task automatic test_backpressure();
    applyReset();
    imemAck = 1'b1; instrReady = 1'b0;
    releaseReset();
    repeat (4) step();
    check32("bp_level_full", 32'(fifoLevel), 32'd4);
    check32("bp_valid_low", 32'(imemValid), 32'd0);
    check32("bp_addr_hold", imemAddr, 32'h10);
    step();
    check32("bp_addr_hold2", imemAddr, 32'h10);
    check32("bp_level_hold", 32'(fifoLevel), 32'd4);
    instrReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check32("bp_pop_pc", pc, 32'(4*i));
      check32("bp_pop_instr", instr, 32'(4*i) ^ DATA_KEY);
      step();
      if (i == 0) begin
        check32("bp_resume_valid", 32'(imemValid), 32'd1);
        check32("bp_resume_addr", imemAddr, 32'h10);
      end
    end
  endtask

  task automatic test_slow_ack();
    logic [31:0] expAddr;
    logic [31:0] expOut;
    int          outCount;
    logic        ackNow;
    applyReset();
    instrReady = 1'b1;
    releaseReset();
    expAddr = 32'h0; expOut = 32'h0; outCount = 0;
    for (int c = 0; c < 15; c++) begin
      ackNow  = (c % 3 == 0);
      imemAck = ackNow;
      #1;
      check32("sa_addr", imemAddr, expAddr);
      if (instrValid) begin
        check32("sa_pc", pc, expOut);
        check32("sa_instr", instr, expOut ^ DATA_KEY);
        expOut = expOut + 32'd4;
        outCount++;
      end
      step();
      if (ackNow) expAddr = expAddr + 32'd4;
    end
    check32("sa_out_count", 32'(outCount), 32'd5);
  endtask

  task automatic test_redirect_flush();
    applyReset();
    imemAck = 1'b1; instrReady = 1'b0;
    releaseReset();
    repeat (3) step();
    check32("rd_level3", 32'(fifoLevel), 32'd3);
    check32("rd_addr_pre", imemAddr, 32'hC);
    redirect = 1'b1; redirectPc = 32'h203;
    #1;
    check32("rd_head_unmasked", 32'(instrValid), 32'd1);
    check32("rd_ack_lands", 32'(imemValid), 32'd1);
    step();
    redirect = 1'b0; imemAck = 1'b0;
    #1;
    check32("rd_level0", 32'(fifoLevel), 32'd0);
    check32("rd_addr", imemAddr, 32'h200);
    check32("rd_empty", 32'(instrValid), 32'd0);
    instrReady = 1'b1; imemAck = 1'b1;
    step();
    check32("rd_first_pc", pc, 32'h200);
    check32("rd_first_instr", instr, 32'h200 ^ DATA_KEY);
    step();
    check32("rd_second_pc", pc, 32'h204);
  endtask

  task automatic test_back_to_back();
    logic [31:0] expOut;
    applyReset();
    imemAck = 1'b1; instrReady = 1'b0;
    releaseReset();
    repeat (2) step();
    instrReady = 1'b1;
    expOut = 32'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check32("bb_level", 32'(fifoLevel), 32'd2);
      check32("bb_pc", pc, expOut);
      expOut = expOut + 32'd4;
      step();
    end
    redirect = 1'b1; redirectPc = 32'h40;
    step();
    redirectPc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0; imemAck = 1'b0;
    #1;
    check32("bb_wrap_addr", imemAddr, 32'hFFFF_FFFC);
    check32("bb_wrap_level", 32'(fifoLevel), 32'd0);
    imemAck = 1'b1;
    step();
    check32("bb_wrap_next", imemAddr, 32'h0);
    check32("bb_wrap_pc", pc, 32'hFFFF_FFFC);
    step();
    check32("bb_wrap_pc0", pc, 32'h0);
    check32("bb_wrap_addr4", imemAddr, 32'h4);
  endtask

  task automatic test_async_reset();
    applyReset();
    imemAck = 1'b1; instrReady = 1'b0;
    releaseReset();
    repeat (3) step();
    check32("ar_level3", 32'(fifoLevel), 32'd3);
    #2;
    rstN = 1'b0;
    #1;
    check32("ar_level", 32'(fifoLevel), 32'd0);
    check32("ar_instr_valid", 32'(instrValid), 32'd0);
    check32("ar_imem_valid", 32'(imemValid), 32'd0);
    check32("ar_instr", instr, 32'd0);
    check32("ar_pc", pc, 32'd0);
    check32("ar_addr", imemAddr, 32'd0);
    step();
    check32("ar_no_push", 32'(fifoLevel), 32'd0);
    releaseReset();
    #1;
    check32("ar_rel_addr", imemAddr, 32'd0);
    check32("ar_rel_valid", 32'(imemValid), 32'd1);
    step();
    check32("ar_rel_level", 32'(fifoLevel), 32'd1);
    check32("ar_rel_pc", pc, 32'd0);
  endtask

  // Scenario sequence
  initial begin
    rstN = 1'b0; redirect = 1'b0; redirectPc = '0; imemAck = 1'b0; instrReady = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_slow_ack();
    test_redirect_flush();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
